// File: rtl/ula_md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and FSM
// encodings, latency constants and small op-decoding helpers.
package ula_md_pkg;

  // Default operand width and the matching latencies (cycles from start to pronto)
  localparam int BITS_PADRAO   = 64;
  localparam int MD_LAT        = BITS_PADRAO + 2;
  localparam int MD_LAT_RAPIDA = 1;

  // funct3 encoding of the M-extension ops
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    OCIOSO,
    CALCULA,
    AJUSTE,
    PRONTO
  } md_estado_e;

  // Normal latency for an arbitrary width
  function automatic int md_lat(input int bits);
    return bits + 2;
  endfunction

  // dina is treated as signed
  function automatic logic op_sinal_a(input md_op_e o);
    return o inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // dinb is treated as signed
  function automatic logic op_sinal_b(input md_op_e o);
    return o inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_e_div(input md_op_e o);
    return o[2];
  endfunction

  function automatic logic op_e_rem(input md_op_e o);
    return o[2] & o[1];
  endfunction

endpackage

// File: rtl/SomadorSubtrator.sv
// Plain add/subtract: s = a + b (sub=0) or s = a - b (sub=1), modulo 2^W.
module SomadorSubtrator #(
  parameter int W = 65
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] s_o
);

  assign s_o = a_i + (b_i ^ {W{sub_i}}) + {{(W-1){1'b0}}, sub_i};

endmodule

// File: rtl/ula_mul_div.sv
// Iterative RISC-V M-extension multiply/divide unit with start/busy/done
// handshake. Unsigned shift-add multiply and restoring divide on operand
// magnitudes, followed by a one-cycle sign adjustment.
// Build option: ULA_MUL_DIV_DIVISAO_EN enables the divider; without it the
// divide ops complete in one cycle with dout=0 and op_invalida=1.
module ula_mul_div
  import ula_md_pkg::*;
#(
  parameter int BITS = BITS_PADRAO
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            cancela,
  input  logic [2:0]      op,
  input  logic [BITS-1:0] dina,
  input  logic [BITS-1:0] dinb,
  output logic [BITS-1:0] dout,
  output logic            ocupado,
  output logic            pronto,
  output logic            op_invalida
);

  localparam int CW = $clog2(BITS);
  // Last iteration index: the normal latency minus accept, adjust and done cycles
  localparam logic [CW-1:0] CNT_FIM = CW'(md_lat(BITS) - 3);
`ifdef ULA_MUL_DIV_DIVISAO_EN
  localparam logic [BITS-1:0] MAIS_NEG = {1'b1, {(BITS-1){1'b0}}};
`endif

  md_estado_e      estado_q, estado_d;
  md_op_e          op_q, op_d;
  md_op_e          op_in;
  logic            neg_a_q, neg_a_d;       // dividend (dina) was negative and signed
  logic            neg_res_q, neg_res_d;   // operand signs differ
  logic            inval_q, inval_d;
  logic [BITS-1:0] hi_q, hi_d;             // product high half / remainder
  logic [BITS-1:0] lo_q, lo_d;             // multiplier->product low / dividend->quotient
  logic [BITS-1:0] b_q, b_d;               // |multiplicand| or |divisor|
  logic [BITS-1:0] dout_q, dout_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            aceita;
  logic            sa_in, sb_in;
  logic [BITS-1:0] mag_a, mag_b;
  logic            rapido, inval_in;
  logic [BITS-1:0] rapido_res;
`ifdef ULA_MUL_DIV_DIVISAO_EN
  logic            div_zero, div_ovf;
`endif

  logic [BITS:0]   soma_a, soma_b, soma_s;
  logic            soma_sub;

  logic            sel_lo, negar, borrow_hi;
  logic [BITS-1:0] sel_res, res_ajuste;

  assign op_in  = md_op_e'(op);
  assign aceita = (estado_q == OCIOSO) && start && !cancela;

  // Decode an incoming request: operand signs, magnitudes and the 1-cycle fast path
  always_comb begin
    sa_in      = op_sinal_a(op_in) & dina[BITS-1];
    sb_in      = op_sinal_b(op_in) & dinb[BITS-1];
    mag_a      = sa_in ? -dina : dina;
    mag_b      = sb_in ? -dinb : dinb;
    rapido     = 1'b0;
    inval_in   = 1'b0;
    rapido_res = '0;
`ifdef ULA_MUL_DIV_DIVISAO_EN
    div_zero = op_e_div(op_in) && (dinb == '0);
    div_ovf  = (op_in == OP_DIV || op_in == OP_REM) && (dina == MAIS_NEG) && (dinb == '1);
    rapido   = div_zero | div_ovf;
    if (div_zero) begin
      rapido_res = op_e_rem(op_in) ? dina : '1;
    end else if (div_ovf) begin
      rapido_res = op_e_rem(op_in) ? '0 : dina;
    end
`else
    rapido   = op_e_div(op_in);
    inval_in = op_e_div(op_in);
`endif
  end

  // Sign adjustment: pick the result half and decide whether it is negated.
  // Negating the high half of a product borrows from the low half unless it is zero.
  assign sel_lo     = (op_q == OP_MUL) || (op_q[2] && !op_q[1]);
  assign sel_res    = sel_lo ? lo_q : hi_q;
  assign negar      = op_e_rem(op_q) ? neg_a_q : neg_res_q;
  assign borrow_hi  = !sel_lo && !op_q[2] && (lo_q != '0);
  assign res_ajuste = negar ? soma_s[BITS-1:0] : sel_res;

  // Route the shared adder: shift-add or trial subtract while iterating, negation while adjusting
  always_comb begin
    soma_a   = {1'b0, hi_q};
    soma_b   = {1'b0, b_q};
    soma_sub = 1'b0;
    if (estado_q == AJUSTE) begin
      soma_a   = borrow_hi ? '1 : '0;
      soma_b   = {1'b0, sel_res};
      soma_sub = 1'b1;
    end
`ifdef ULA_MUL_DIV_DIVISAO_EN
    else if (op_e_div(op_q)) begin
      soma_a   = {hi_q, lo_q[BITS-1]};
      soma_sub = 1'b1;
    end
`endif
  end

  SomadorSubtrator #(
    .W (BITS + 1)
  ) u_somador (
    .a_i   (soma_a),
    .b_i   (soma_b),
    .sub_i (soma_sub),
    .s_o   (soma_s)
  );

  // FSM next state and handshake outputs
  always_comb begin
    estado_d    = estado_q;
    ocupado     = (estado_q == CALCULA) || (estado_q == AJUSTE);
    pronto      = (estado_q == PRONTO);
    op_invalida = (estado_q == PRONTO) && inval_q;
    case (estado_q)
      OCIOSO:  if (aceita) estado_d = rapido ? PRONTO : CALCULA;
      CALCULA: if (cnt_q == CNT_FIM) estado_d = AJUSTE;
      AJUSTE:  estado_d = PRONTO;
      PRONTO:  estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
    // A flush always returns to idle, dropping any partial result
    if (cancela) begin
      estado_d = OCIOSO;
    end
  end

  // Datapath next state: operand capture, one iteration per cycle, result latch
  always_comb begin
    op_d      = op_q;
    neg_a_d   = neg_a_q;
    neg_res_d = neg_res_q;
    inval_d   = inval_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    case (estado_q)
      OCIOSO: begin
        if (aceita) begin
          op_d      = op_in;
          neg_a_d   = sa_in;
          neg_res_d = sa_in ^ sb_in;
          inval_d   = inval_in;
          cnt_d     = '0;
          hi_d      = '0;
          if (op_e_div(op_in)) begin
            lo_d = mag_a;
            b_d  = mag_b;
          end else begin
            lo_d = mag_b;
            b_d  = mag_a;
          end
          if (rapido) begin
            dout_d = rapido_res;
          end
        end
      end
      CALCULA: begin
        cnt_d = cnt_q + 1'b1;
`ifdef ULA_MUL_DIV_DIVISAO_EN
        if (op_e_div(op_q)) begin
          // Restoring step: keep the difference only when it did not go negative
          lo_d = {lo_q[BITS-2:0], !soma_s[BITS]};
          hi_d = soma_s[BITS] ? {hi_q[BITS-2:0], lo_q[BITS-1]} : soma_s[BITS-1:0];
        end else
`endif
        begin
          // Shift-add step: conditionally add multiplicand to the high half, then shift right
          {hi_d, lo_d} = {(lo_q[0] ? soma_s : {1'b0, hi_q}), lo_q[BITS-1:1]};
        end
      end
      AJUSTE: begin
        if (!cancela) begin
          dout_d = res_ajuste;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q  <= OCIOSO;
      op_q      <= OP_MUL;
      neg_a_q   <= 1'b0;
      neg_res_q <= 1'b0;
      inval_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
    end else begin
      estado_q  <= estado_d;
      op_q      <= op_d;
      neg_a_q   <= neg_a_d;
      neg_res_q <= neg_res_d;
      inval_q   <= inval_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule
